adder_mp_sequencer: RTL and testbench

Multi-precision adder sequencer. It adds two WIDTH×NUM_CHUNKS-bit operands by time-multiplexing one internal WIDTH-bit Adder_Nbits instance, processing one chunk per cycle, LSB chunk first. A registered carry links consecutive chunks. It sits between a wide-operand producer and consumer and uses valid/ready handshakes on both sides, so wide additions cost one narrow adder instead of a full-width carry chain.

---
 rtl/adder_mp_sequencer.sv | 159 +++++++++++++++
 tb/tb_adder_mp_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_mp_sequencer.sv
// Multi-precision adder: one WIDTH-bit adder stepped over NUM_CHUNKS chunks.
// Optional subtract support is enabled by defining ADDER_SEQ_SUB_EN.
module Adder_Nbits #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  input  logic         i_Cin,
  output logic [N-1:0] o_Sum,
  output logic         o_Cout
);

  assign {o_Cout, o_Sum} = {1'b0, i_A} + {1'b0, i_B} + {{N{1'b0}}, i_Cin};

endmodule

module adder_mp_sequencer #(
  parameter int WIDTH      = 16,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [WIDTH*NUM_CHUNKS-1:0] i_A,
  input  logic [WIDTH*NUM_CHUNKS-1:0] i_B,
  input  logic                        i_Cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                        i_sub,
`endif
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [WIDTH*NUM_CHUNKS-1:0] o_Sum,
  output logic                        o_Cout,
  output logic                        o_busy
);

  localparam int W  = WIDTH * NUM_CHUNKS;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [WIDTH-1:0] a_chunk;
  logic [WIDTH-1:0] b_chunk;
  logic [WIDTH-1:0] add_sum;
  logic            add_cout;
  int              base;

`ifdef ADDER_SEQ_SUB_EN
  logic sub_q, sub_d;
`endif

  assign base    = int'(cnt_q) * WIDTH;
  assign a_chunk = a_q[base +: WIDTH];

  // Subtraction is A + ~B + 1; the +1 comes from the preloaded carry.
`ifdef ADDER_SEQ_SUB_EN
  assign b_chunk = sub_q ? ~b_q[base +: WIDTH] : b_q[base +: WIDTH];
`else
  assign b_chunk = b_q[base +: WIDTH];
`endif

  Adder_Nbits #(
    .N(WIDTH)
  ) u_add (
    .i_A   (a_chunk),
    .i_B   (b_chunk),
    .i_Cin (carry_q),
    .o_Sum (add_sum),
    .o_Cout(add_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_A;
          b_d     = i_B;
          cnt_d   = '0;
`ifdef ADDER_SEQ_SUB_EN
          sub_d   = i_sub;
          carry_d = i_sub ? 1'b1 : i_Cin;
`else
          carry_d = i_Cin;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[base +: WIDTH] = add_sum;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = add_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q != S_IDLE);
  assign o_Sum   = sum_q;
  assign o_Cout  = cout_q;

endmodule

// File: tb/tb_adder_mp_sequencer.sv
// Randomized and directed bench for adder_mp_sequencer with an arithmetic model.
// Subtract scenarios run when ADDER_SEQ_SUB_EN is defined.
module tb_adder_mp_sequencer;

  localparam int WIDTH = 16;
  localparam int NC    = 4;
  localparam int W     = WIDTH * NC;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic         i_Cin;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_Sum;
  logic         o_Cout;
  logic         o_busy;
  logic         sub_eff;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit         m_busy;
  int         m_cnt;
  logic [W:0] m_res;

  always #5 i_clk = ~i_clk;

  adder_mp_sequencer #(
    .WIDTH(WIDTH),
    .NUM_CHUNKS(NC)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_A    (i_A),
    .i_B    (i_B),
    .i_Cin  (i_Cin),
`ifdef ADDER_SEQ_SUB_EN
    .i_sub  (i_sub),
`endif
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_Sum  (o_Sum),
    .o_Cout (o_Cout),
    .o_busy (o_busy)
  );

`ifdef ADDER_SEQ_SUB_EN
  assign sub_eff = i_sub;
`else
  assign sub_eff = 1'b0;
`endif

  function automatic logic [W:0] ref_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c,
    input logic         s
  );
    if (s) return {1'b0, a} + {1'b0, ~b} + 65'd1;
    return {1'b0, a} + {1'b0, b} + 65'(c);
  endfunction

  task automatic check(
    input string      nm,
    input logic [W:0] act,
    input logic [W:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Model: an op is a fixed NC-cycle delay, then held until i_ready.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_busy) begin
      if (i_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_res  <= ref_op(i_A, i_B, i_Cin, sub_eff);
      end
    end else if (m_cnt < NC) begin
      m_cnt <= m_cnt + 1;
    end else if (i_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      check("rst_ready", 65'(o_ready), 65'd1);
      check("rst_valid", 65'(o_valid), 65'd0);
      check("rst_busy", 65'(o_busy), 65'd0);
      check("rst_sum", {o_Cout, o_Sum}, '0);
    end else begin
      check("ready", 65'(o_ready), 65'(!m_busy));
      check("busy", 65'(o_busy), 65'(m_busy));
      check("valid", 65'(o_valid), 65'(m_busy && m_cnt == NC));
      if (m_busy && m_cnt == NC)
        check("result", {o_Cout, o_Sum}, m_res);
    end
  end

  task automatic send(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c,
    input logic         s
  );
    int k;
    @(posedge i_clk);
    #1;
    i_A = a;
    i_B = b;
    i_Cin = c;
    i_sub = s;
    i_valid = 1'b1;
    k = 0;
    @(negedge i_clk);
    while (!o_ready && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_ready) timeout("accept");
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(
    output int         lat,
    output logic [W-1:0] s,
    output logic       c
  );
    lat = 0;
    @(negedge i_clk);
    while (!o_valid && lat < 50) begin
      @(negedge i_clk);
      lat++;
    end
    if (!o_valid) timeout("valid");
    s = o_Sum;
    c = o_Cout;
  endtask

  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    input  logic         s,
    output logic [W-1:0] sum,
    output logic         cout,
    output int           lat
  );
    i_ready = 1'b0;
    send(a, b, c, s);
    wait_valid(lat, sum, cout);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] s, s0;
    logic         c;
    int           lat, k;
    int           t[3];
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_A = '0;
    i_B = '0;
    i_Cin = 1'b0;
    i_sub = 1'b0;
    i_ready = 1'b0;
    #2;
    check("init_ready", 65'(o_ready), 65'd1);
    check("init_sum", {o_Cout, o_Sum}, '0);
    #10;
    i_rst_n = 1'b1;

    run_op(64'hFFFF, 64'h1, 1'b0, 1'b0, s, c, lat);
    check("carry_sum", {1'b0, s}, 65'h1_0000);
    check("carry_cout", 65'(c), 65'd0);
    check("carry_lat", 65'(lat), 65'd4);

    run_op('1, '0, 1'b1, 1'b0, s, c, lat);
    check("ripple_sum", {1'b0, s}, 65'd0);
    check("ripple_cout", 65'(c), 65'd1);

    i_ready = 1'b0;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    wait_valid(lat, s0, c);
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk);
      #1;
      i_A = {$urandom, $urandom};
      i_B = {$urandom, $urandom};
      i_valid = (i % 2 == 0);
      @(negedge i_clk);
      check("bp_valid", 65'(o_valid), 65'd1);
      check("bp_ready", 65'(o_ready), 65'd0);
      check("bp_sum", {1'b0, o_Sum}, {1'b0, s0});
    end
    @(posedge i_clk);
    #1;
    i_A = 64'd100;
    i_B = 64'd23;
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("bp_idle", 65'(o_ready), 65'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    check("bp_accept", 65'(o_busy), 65'd1);
    i_valid = 1'b0;
    wait_valid(lat, s, c);
    check("bp_held_sum", {1'b0, s}, 65'd123);
    repeat (3) @(posedge i_clk);

    i_ready = 1'b0;
    send(64'h1234, 64'h5678, 1'b0, 1'b0);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 65'(o_valid), 65'd0);
    check("mid_rst_busy", 65'(o_busy), 65'd0);
    check("mid_rst_ready", 65'(o_ready), 65'd1);
    check("mid_rst_sum", {o_Cout, o_Sum}, '0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    run_op(64'd5, 64'd7, 1'b0, 1'b0, s, c, lat);
    check("post_rst_sum", {c, s}, 65'd12);

    for (int p = 0; p < 3; p++) begin
      pa[p] = {$urandom, $urandom};
      pb[p] = {$urandom, $urandom};
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_A = pa[0];
    i_B = pb[0];
    i_Cin = 1'b0;
    i_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      k = 0;
      @(negedge i_clk);
      while (!o_ready && k < 50) begin
        @(negedge i_clk);
        k++;
      end
      if (!o_ready) timeout("b2b_accept");
      @(posedge i_clk);
      #1;
      t[p] = cyc;
      if (p < 2) begin
        i_A = pa[p+1];
        i_B = pb[p+1];
      end else begin
        i_valid = 1'b0;
      end
    end
    check("b2b_gap0", 65'(t[1] - t[0]), 65'd6);
    check("b2b_gap1", 65'(t[2] - t[1]), 65'd6);
    repeat (8) @(posedge i_clk);

`ifdef ADDER_SEQ_SUB_EN
    run_op(64'h10, 64'h11, 1'b0, 1'b1, s, c, lat);
    check("sub_neg", {c, s}, {1'b0, {W{1'b1}}});
    run_op(64'h11, 64'h10, 1'b1, 1'b1, s, c, lat);
    check("sub_pos", {c, s}, {1'b1, 64'd1});
`endif

    for (int i = 0; i < 400; i++) begin
      @(posedge i_clk);
      #1;
      i_A = {$urandom, $urandom};
      i_B = {$urandom, $urandom};
      if ($urandom % 4 == 0) begin
        i_A = '1;
        i_B = 64'(i);
      end
      i_Cin = 1'($urandom);
      i_sub = 1'($urandom);
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
